stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button synchronisation, edge detection and the
// IDLE/RUN/PAUSE/DONE state machine that drives the counter datapath.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_dir,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_clr,
  input  logic       at_zero,
  input  logic       at_max,
  output logic       inc,
  output logic       dec,
  output logic       clr,
  output logic       dir_down,
  output logic [1:0] state
);

  localparam int unsigned   TW        = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 32'd1);

  localparam int unsigned B_DEC   = 0;
  localparam int unsigned B_INC   = 1;
  localparam int unsigned B_DIR   = 2;
  localparam int unsigned B_START = 3;
  localparam int unsigned B_CLR   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  logic [4:0]    btn_raw_s;
  logic [4:0]    sync1_r;
  logic [4:0]    sync2_r;
  logic [4:0]    prev_r;
  logic [4:0]    ev_s;
  logic [2:0]    arm_r;
  logic          ev_clr_s;
  logic          ev_start_s;
  logic          ev_dir_s;
  logic          ev_inc_s;
  logic          ev_dec_s;
  logic          step_s;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          dir_r;
  logic          dir_nxt_s;
  logic [TW-1:0] tick_r;
  logic [TW-1:0] tick_nxt_s;
  logic          inc_r;
  logic          inc_nxt_s;
  logic          dec_r;
  logic          dec_nxt_s;
  logic          clr_r;
  logic          clr_nxt_s;

  assign btn_raw_s = {btn_clr, btn_start, btn_dir, btn_inc, btn_dec};

  // Two-flop synchronisers, edge-history flops and the post-reset arming shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
      prev_r  <= 5'b00000;
      arm_r   <= 3'b000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      arm_r   <= {arm_r[1:0], 1'b1};
    end
  end

  // Edges are only trusted once the pipeline holds post-reset samples, so a
  // button held through reset release never looks like a fresh press.
  assign ev_s       = sync2_r & ~prev_r & {5{arm_r[2]}};
  assign ev_clr_s   = ev_s[B_CLR];
  assign ev_start_s = ev_s[B_START] & ~ev_clr_s;
  assign ev_dir_s   = ev_s[B_DIR] & ~ev_clr_s & ~ev_start_s;
  assign ev_inc_s   = ev_s[B_INC] & ~ev_clr_s & ~ev_start_s & ~ev_dir_s;
  assign ev_dec_s   = ev_s[B_DEC] & ~ev_clr_s & ~ev_start_s & ~ev_dir_s;
  assign step_s     = (tick_r == TICK_LAST);

  // Next-state, prescaler and command decode.
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    tick_nxt_s  = tick_r;
    inc_nxt_s   = 1'b0;
    dec_nxt_s   = 1'b0;
    clr_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tick_nxt_s = '0;
        if (ev_clr_s) begin
          clr_nxt_s = 1'b1;
        end else if (ev_start_s) begin
          state_nxt_s = ST_RUN;
        end else if (ev_dir_s) begin
          dir_nxt_s = ~dir_r;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ev_clr_s) begin
          clr_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
          tick_nxt_s  = '0;
        end else if (step_s) begin
          // A step at the limit ends the run even if start was pressed.
          tick_nxt_s = '0;
          if (!dir_r && !at_max) begin
            inc_nxt_s   = 1'b1;
            state_nxt_s = ev_start_s ? ST_PAUSE : ST_RUN;
          end else if (dir_r && !at_zero) begin
            dec_nxt_s   = 1'b1;
            state_nxt_s = ev_start_s ? ST_PAUSE : ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          tick_nxt_s  = tick_r + TW'(1);
          state_nxt_s = ev_start_s ? ST_PAUSE : ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (ev_clr_s) begin
          clr_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
          tick_nxt_s  = '0;
        end else if (ev_start_s) begin
          state_nxt_s = ST_RUN;
        end else if (ev_dir_s) begin
          dir_nxt_s = ~dir_r;
        end else if (ev_inc_s && !ev_dec_s) begin
          inc_nxt_s = ~at_max;
        end else if (ev_dec_s && !ev_inc_s) begin
          dec_nxt_s = ~at_zero;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      ST_DONE: begin
        tick_nxt_s = '0;
        if (ev_clr_s) begin
          clr_nxt_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tick_nxt_s  = '0;
      end
    endcase
  end

  // State, direction, prescaler and registered command outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b0;
      tick_r  <= '0;
      inc_r   <= 1'b0;
      dec_r   <= 1'b0;
      clr_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      dir_r   <= dir_nxt_s;
      tick_r  <= tick_nxt_s;
      inc_r   <= inc_nxt_s;
      dec_r   <= dec_nxt_s;
      clr_r   <= clr_nxt_s;
    end
  end

  assign inc      = inc_r;
  assign dec      = dec_r;
  assign clr      = clr_r;
  assign dir_down = dir_r;
  assign state    = state_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (TICK_DIV=4): directed scenarios plus a random
// phase, all checked every cycle against a press-level reference model.
module tb_stopwatch_ctrl;

  localparam int TICK = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam int W_RUN = 0, W_PAUSE = 1, W_DONE = 2, W_INC = 3, W_DEC = 4, W_CLR = 5;

  logic       clk = 1'b0;
  logic       rst_n, btn_start, btn_dir, btn_inc, btn_dec, btn_clr, at_zero, at_max;
  logic       inc, dec, clr, dir_down;
  logic [1:0] state;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int m_state = 0, m_dir = 0, m_inc = 0, m_dec = 0, m_clr = 0, m_run = 0, m_since = 0;
  bit [3:0] h_start = 4'b0, h_dir = 4'b0, h_inc = 4'b0, h_dec = 4'b0, h_clr = 4'b0;

  stopwatch_ctrl #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_dir(btn_dir),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_clr(btn_clr),
    .at_zero(at_zero), .at_max(at_max), .inc(inc), .dec(dec), .clr(clr),
    .dir_down(dir_down), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: a press counts 3 edges after it is sampled high following a low
  // sample, provided both samples were taken after reset release.
  task automatic model_step();
    bit armed, e_clr, e_start, e_dir, e_inc, e_dec;
    h_start = {h_start[2:0], btn_start};
    h_dir   = {h_dir[2:0], btn_dir};
    h_inc   = {h_inc[2:0], btn_inc};
    h_dec   = {h_dec[2:0], btn_dec};
    h_clr   = {h_clr[2:0], btn_clr};
    if (rst_n !== 1'b1) begin
      m_state = S_IDLE; m_dir = 0; m_inc = 0; m_dec = 0; m_clr = 0; m_run = 0; m_since = 0;
      return;
    end
    if (m_since < 4) m_since++;
    armed   = (m_since >= 4);
    e_clr   = armed && h_clr[2] && !h_clr[3];
    e_start = armed && h_start[2] && !h_start[3];
    e_dir   = armed && h_dir[2] && !h_dir[3];
    e_inc   = armed && h_inc[2] && !h_inc[3];
    e_dec   = armed && h_dec[2] && !h_dec[3];
    m_inc = 0; m_dec = 0; m_clr = 0;
    if (e_clr) begin
      m_clr = 1; m_state = S_IDLE; m_run = 0;
    end else begin
      case (m_state)
        S_IDLE: begin
          if (e_start) m_state = S_RUN;
          else if (e_dir) m_dir = 1 - m_dir;
        end
        S_RUN: begin
          m_run++;
          if (m_run % TICK == 0) begin
            if (m_dir == 0 && !at_max) m_inc = 1;
            else if (m_dir == 1 && !at_zero) m_dec = 1;
            else begin m_state = S_DONE; m_run = 0; end
          end
          if (e_start && m_state == S_RUN) m_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (e_start) m_state = S_RUN;
          else if (e_dir) m_dir = 1 - m_dir;
          else if (e_inc && !e_dec && !at_max) m_inc = 1;
          else if (e_dec && !e_inc && !at_zero) m_dec = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("model", int'({state, dir_down, inc, dec, clr}),
            m_state * 16 + m_dir * 8 + m_inc * 4 + m_dec * 2 + m_clr);
      check("inc_dec_excl", int'(inc & dec), 0);
    end
  endtask

  task automatic cyc_count(input int n, output int ni, output int nd);
    ni = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (inc === 1'b1) ni++;
      if (dec === 1'b1) nd++;
    end
  endtask

  function automatic bit hit(input int sel);
    case (sel)
      W_RUN:   return state === 2'b01;
      W_PAUSE: return state === 2'b10;
      W_DONE:  return state === 2'b11;
      W_INC:   return inc === 1'b1;
      W_DEC:   return dec === 1'b1;
      W_CLR:   return clr === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the number of edges until the condition holds, budget+1 on timeout.
  task automatic wait_for(input int sel, input int budget, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n <= budget) begin
      cyc(1);
      n++;
      found = hit(sel);
    end
  endtask

  initial begin
    int n, ni, nd;
    rst_n = 1'b0; btn_start = 1'b0; btn_dir = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    btn_clr = 1'b0; at_zero = 1'b1; at_max = 1'b0;
    @(negedge clk);
    cyc(3);
    check("reset_outputs", int'({state, dir_down, inc, dec, clr}), 0);
    rst_n = 1'b1;
    cyc(4);

    // Start, then steady up-count every TICK cycles.
    at_zero = 1'b0;
    btn_start = 1'b1; wait_for(W_RUN, 10, n); check("start_latency", n, 3);
    btn_start = 1'b0;
    wait_for(W_INC, 10, n); check("first_inc", n, 4);
    wait_for(W_INC, 10, n); check("inc_period_a", n, 4);
    wait_for(W_INC, 10, n); check("inc_period_b", n, 4);

    // Limit reached: DONE without a pulse, then clear.
    at_max = 1'b1;
    cyc_count(4, ni, nd); check("no_inc_at_max", ni, 0);
    check("done_state", int'(state), 3);
    btn_clr = 1'b1; wait_for(W_CLR, 10, n); check("clr_latency", n, 3);
    check("idle_after_clr", int'(state), 0);
    btn_clr = 1'b0; cyc(1); check("clr_one_cycle", int'(clr), 0);
    at_max = 1'b0;

    // Into PAUSE; dir toggle, cancelling inc+dec, then a manual dec.
    btn_start = 1'b1; wait_for(W_RUN, 10, n); btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; wait_for(W_PAUSE, 10, n); check("pause_latency", n, 3);
    btn_start = 1'b0;
    btn_dir = 1'b1; cyc(1); btn_dir = 1'b0;
    btn_inc = 1'b1; btn_dec = 1'b1; cyc(1); btn_inc = 1'b0; btn_dec = 1'b0;
    cyc_count(5, ni, nd);
    check("dir_toggle", int'(dir_down), 1);
    check("cancel_pulses", ni + nd, 0);
    btn_dec = 1'b1; cyc_count(6, ni, nd); btn_dec = 1'b0;
    check("manual_dec", nd, 1);
    check("manual_dec_no_inc", ni, 0);

    // Pause 2 cycles after a step; resume steps 2 cycles after re-entry.
    btn_start = 1'b1; wait_for(W_RUN, 10, n); btn_start = 1'b0;
    wait_for(W_DEC, 10, n);
    cyc(3); btn_start = 1'b1; wait_for(W_PAUSE, 10, n); check("pause_after_step", n, 3);
    btn_start = 1'b0; cyc(2);
    btn_start = 1'b1; wait_for(W_RUN, 10, n); btn_start = 1'b0;
    wait_for(W_DEC, 10, n); check("resume_step", n, 2);

    // Start coinciding with a step: pulse and PAUSE together.
    cyc(1); btn_start = 1'b1; wait_for(W_PAUSE, 10, n); check("step_pause_latency", n, 3);
    check("step_with_pause", int'(dec), 1);
    btn_start = 1'b0; cyc(1);

    // clr and start together in RUN: clr wins.
    btn_start = 1'b1; wait_for(W_RUN, 10, n); btn_start = 1'b0; cyc(1);
    btn_clr = 1'b1; btn_start = 1'b1; wait_for(W_CLR, 10, n); check("clr_start_latency", n, 3);
    check("clr_over_start", int'(state), 0);
    btn_clr = 1'b0; btn_start = 1'b0; cyc(4);
    check("no_pause", int'(state), 0);

    // Held inc in PAUSE gives one pulse; reset mid-RUN; held start across reset.
    btn_start = 1'b1; wait_for(W_RUN, 10, n); btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; wait_for(W_PAUSE, 10, n); btn_start = 1'b0;
    btn_dir = 1'b1; cyc(1); btn_dir = 1'b0; cyc(4);
    btn_inc = 1'b1; cyc_count(50, ni, nd); btn_inc = 1'b0;
    check("held_inc", ni, 1);
    btn_start = 1'b1; wait_for(W_RUN, 10, n); cyc(2);
    rst_n = 1'b0; cyc(1);
    check("reset_mid_run", int'({state, dir_down, inc, dec, clr}), 0);
    cyc(2); rst_n = 1'b1; cyc(10);
    check("held_through_reset", int'(state), 0);
    btn_start = 1'b0; cyc(3);

    // Random phase, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 5) == 0) btn_dir   = ~btn_dir;
      if ($urandom_range(0, 3) == 0) btn_inc   = ~btn_inc;
      if ($urandom_range(0, 3) == 0) btn_dec   = ~btn_dec;
      if ($urandom_range(0, 15) == 0) btn_clr  = ~btn_clr;
      at_max  = ($urandom_range(0, 9) == 0);
      at_zero = ($urandom_range(0, 9) == 0);
      rst_n   = ($urandom_range(0, 399) != 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
